// File: rtl/bpsk_pkg.sv
// Shared types and default constants for the BPSK link's UART packet transmitter.
package bpsk_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } uart_tx_state_t;

  localparam int unsigned PACKET_SIZE_DEF  = 32;
  localparam int unsigned CLKS_PER_BIT_DEF = 868;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud divider: counts CLKS_PER_BIT clocks while enabled and flags each bit boundary.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(CLKS_PER_BIT - 1));
  assign tick   = enable && w_wrap;

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/packet_uart_tx.sv
// Serialises a whole demodulated packet as back-to-back 8N1 bytes, most significant byte first,
// then pulses done/clear so the upstream buffer can be emptied.
module packet_uart_tx
  import bpsk_pkg::*;
#(
  parameter int unsigned PACKET_SIZE  = PACKET_SIZE_DEF,
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PACKET_SIZE-1:0] sys_packet,
  input  logic                   send,
  output logic                   tx,
  output logic                   busy,
  output logic                   done,
  output logic                   clear
);

  localparam int unsigned NBYTES = PACKET_SIZE / 8;
  localparam int unsigned BW     = $clog2(NBYTES) + 1;

  uart_tx_state_t         r_state, w_state_nxt;
  logic [PACKET_SIZE-1:0] r_shift, w_shift_nxt;
  logic [2:0]             r_bit_idx, w_bit_idx_nxt;
  logic [BW-1:0]          r_byte_cnt, w_byte_cnt_nxt;
  logic [BW-1:0]          w_byte_inc;
  logic [7:0]             w_nxt_byte;
  logic                   r_tx, w_tx_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_clear;
  logic                   r_sync1, r_sync2, r_sync_prev;
  logic                   w_send_rise;
  logic                   w_tick;
  logic                   w_baud_en;

  // send may be asynchronous: double-flop it, then detect the rising edge
  assign w_send_rise = r_sync2 && !r_sync_prev;
  assign w_baud_en   = (r_state == START) || (r_state == DATA) || (r_state == STOP);
  assign w_byte_inc  = r_byte_cnt + BW'(1);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(w_baud_en),
    .tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync_prev <= 1'b0;
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_byte_cnt  <= '0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_clear     <= 1'b0;
    end else begin
      r_sync1     <= send;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_tx        <= w_tx_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_clear     <= w_done_nxt;
    end
  end

  // Outputs are decoded from the next state so tx leads the state register by no cycle
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_idx_nxt  = r_bit_idx;
    w_byte_cnt_nxt = r_byte_cnt;
    w_tx_nxt       = 1'b1;
    w_busy_nxt     = 1'b0;
    w_done_nxt     = 1'b0;
    w_nxt_byte     = 8'h00;

    case (r_state)
      IDLE: begin
        if (w_send_rise) begin
          w_shift_nxt    = sys_packet;
          w_bit_idx_nxt  = '0;
          w_byte_cnt_nxt = '0;
          w_state_nxt    = START;
        end
      end
      START: begin
        if (w_tick) begin
          w_bit_idx_nxt = '0;
          w_state_nxt   = DATA;
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (w_byte_inc == BW'(NBYTES)) begin
            w_state_nxt = DONE;
          end else begin
            w_byte_cnt_nxt = w_byte_inc;
            w_shift_nxt    = r_shift << 8;
            w_state_nxt    = START;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_nxt_byte = w_shift_nxt[PACKET_SIZE-1 -: 8];
    case (w_state_nxt)
      START: begin
        w_tx_nxt   = 1'b0;
        w_busy_nxt = 1'b1;
      end
      DATA: begin
        w_tx_nxt   = w_nxt_byte[w_bit_idx_nxt];
        w_busy_nxt = 1'b1;
      end
      STOP: begin
        w_busy_nxt = 1'b1;
      end
      DONE: begin
        w_done_nxt = 1'b1;
      end
      default: begin
        w_tx_nxt = 1'b1;
      end
    endcase
  end

  assign tx    = r_tx;
  assign busy  = r_busy;
  assign done  = r_done;
  assign clear = r_clear;

endmodule

// File: doc/packet_uart_tx.md
PACKET_UART_TX -- requirements
Module: packet_uart_tx

Interface
REQ-001 Parameter PACKET_SIZE, default 32: packet width in bits; SHALL be a nonzero multiple of 8.
REQ-002 Parameter CLKS_PER_BIT, default 868: clocks per UART bit (100 MHz / 115200); SHALL be >= 2.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 sys_packet  input  PACKET_SIZE  completed packet from the demodulator buffer; stable while send is high.
REQ-006 send  input  1  packet-ready level from the demodulator buffer; may be asynchronous to clk.
REQ-007 tx  output  1  UART serial line, 8N1, idle high.
REQ-008 busy  output  1  high from the first start bit through the last stop bit.
REQ-009 done  output  1  one-cycle pulse after the final stop bit.
REQ-010 clear  output  1  one-cycle pulse, coincident with done, that empties the demodulator buffer.

Function
REQ-011 send SHALL pass through a two-flop synchronizer, then a rising-edge detector on the synchronized value.
REQ-012 In IDLE, a detected rising edge SHALL latch sys_packet into the shift register, set busy, and enter START on the next cycle; tx SHALL go low within 3 clk cycles of send rising.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP, DONE.
REQ-014 IDLE: tx=1, busy=0, baud counter held at 0.
REQ-015 START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
REQ-016 DATA: 8 bits, LSB first, each held exactly CLKS_PER_BIT cycles, then go to STOP.
REQ-017 STOP: tx=1 for CLKS_PER_BIT cycles; then go to START if bytes remain, else go to DONE.
REQ-018 Byte order: most significant byte first, i.e. sys_packet[PACKET_SIZE-1 -: 8] is sent first.
REQ-019 DONE: lasts one cycle with done=1, clear=1, busy=0, tx=1; then go to IDLE.
REQ-020 Baud counter width SHALL be $clog2(CLKS_PER_BIT). It wraps from CLKS_PER_BIT-1 to 0 and asserts the bit tick on wrap.
REQ-021 Byte counter width SHALL be $clog2(PACKET_SIZE/8)+1, compared against PACKET_SIZE/8.
REQ-022 Total frame time SHALL be (PACKET_SIZE/8)*10*CLKS_PER_BIT cycles, with no idle gap between bytes.
REQ-023 A send edge while not in IDLE SHALL be ignored; the latched packet is not modified.
REQ-024 send held high after DONE SHALL NOT retrigger; a new frame requires send to fall and then rise.
REQ-025 A send rising edge in the same cycle as DONE SHALL be ignored.

Reset
REQ-026 With rst_n=0 at a clk edge: tx=1, busy=0, done=0, clear=0, state=IDLE, all counters and synchronizer flops 0.
REQ-027 Reset mid-frame SHALL abort immediately: tx high on the next edge, no done/clear pulse, partial byte discarded.
REQ-028 After reset release, an already-high send SHALL count as a rising edge (synchronizer reset value is 0).

Structure
REQ-029 Shared package bpsk_pkg SHALL hold the state enum typedef uart_tx_state_t and the default constants PACKET_SIZE_DEF=32 and CLKS_PER_BIT_DEF=868.
REQ-030 The baud divider SHALL be a separate sub-module, uart_baud_gen (inputs: clk, rst_n, enable; output: tick), held at 0 while enable=0.
REQ-031 No other sub-modules; the FSM, shift register and synchronizer stay in packet_uart_tx.

Verification (PACKET_SIZE=16, CLKS_PER_BIT=4)
REQ-032 Basic frame: sys_packet=16'hA53C, send raised -> tx sequence 0,1,0,1,0,0,1,0,1,1 then 0,0,0,1,1,1,1,0,0,1, each bit held 4 cycles, busy high 80 cycles, then a single-cycle done and clear.
REQ-033 Retrigger guard: send held high 200 cycles after done -> exactly one frame transmitted.
REQ-034 Busy ignore: second send edge with 16'hFFFF at cycle 20 of a 16'h1234 frame -> only 12 then 34 appear on tx; no second frame.
REQ-035 Mid-frame reset: rst_n low at cycle 30 for 1 cycle -> tx=1 and busy=0 on the next edge, no done or clear pulse; a later send edge with 16'h00FF transmits cleanly.
REQ-036 Back-to-back: send fall then rise 2 cycles after clear -> second frame starts within 3 cycles, bit timing identical to the first.
REQ-037 Byte 8'h00 and 8'hFF: packet 16'h00FF -> start bit, 8 low bits, stop bit, start bit, 8 high bits, stop bit; line high after the final stop bit.
